bus_target_demux: RTL

- Routes one core-side memory request to one of 8 target ports (ROM, RAM, UART, timer, …), selected by the top 3 address bits.
- Returns the selected target's read data and acknowledge to the core.
- Sits between the core load/store path and the peripherals.
- Each transaction is tracked by a small FSM with a per-transaction timeout, so the core never hangs on a dead or unmapped target.

---
 rtl/bus_target_demux_pkg.sv | 18 +
 rtl/bus_target_demux_if.sv | 31 +++
 rtl/bus_timeout_counter.sv | 22 ++
 rtl/bus_target_demux.sv | 93 +++++++++
 4 files changed

// File: rtl/bus_target_demux_pkg.sv
// bus_target_demux_pkg: shared FSM encoding, target geometry and decode helpers
package bus_target_demux_pkg;
    localparam int NUM_TARGETS = 8;
    localparam int IDX_W = 3;
    localparam int IDX_MSB = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [NUM_TARGETS-1:0] onehot(input logic [IDX_W-1:0] i);
        onehot = '0;
        onehot[i] = 1'b1;
    endfunction
endpackage

// File: rtl/bus_target_demux_if.sv
// bus_target_demux_if: core-side request/response and target-side fan-out signals
interface bus_target_demux_if;
    import bus_target_demux_pkg::*;
    logic                        m_valid;
    logic                        m_ready;
    logic                        m_we;
    logic [31:0]                 m_addr;
    logic [31:0]                 m_wdata;
    logic [3:0]                  m_wstrb;
    logic                        m_rvalid;
    logic [31:0]                 m_rdata;
    logic                        m_err;
    logic [NUM_TARGETS-1:0]      s_valid;
    logic [NUM_TARGETS-1:0]      s_ready;
    logic                        s_we;
    logic [31:0]                 s_addr;
    logic [31:0]                 s_wdata;
    logic [3:0]                  s_wstrb;
    logic [NUM_TARGETS-1:0]      s_rvalid;
    logic [32*NUM_TARGETS-1:0]   s_rdata;

    // master: the core and targets around the demux; slave: the demux itself
    modport master (
        output m_valid, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rvalid, s_rdata,
        input  m_ready, m_rvalid, m_rdata, m_err, s_valid, s_we, s_addr, s_wdata, s_wstrb
    );
    modport slave (
        input  m_valid, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rvalid, s_rdata,
        output m_ready, m_rvalid, m_rdata, m_err, s_valid, s_we, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts active transaction cycles and flags the last allowed one
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) cnt <= '0;
        else if (enable) cnt <= cnt + 1'b1;
    end

    assign expired = TIMEOUT != 0 && enable && cnt == LAST;
endmodule

// File: rtl/bus_target_demux.sv
// bus_target_demux: routes one core request to a target by address[31:29] with timeout
module bus_target_demux
    import bus_target_demux_pkg::*;
#(
    parameter logic [NUM_TARGETS-1:0] PRESENT_MASK = 8'hFF,
    parameter int unsigned            TIMEOUT      = 16,
    parameter logic [31:0]            ERR_DATA     = 32'hDEAD_BEEF
) (
    input logic clk,
    input logic reset,
    bus_target_demux_if.slave bus
);
    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       idx, req_idx;
    logic                   we_q, rvalid_q, err_q, err_nxt;
    logic [31:0]            addr_q, wdata_q, rdata_q, slice;
    logic [3:0]             wstrb_q;
    logic [NUM_TARGETS-1:0] s_valid_q;
    logic                   sel_ready, sel_rvalid, expired, active;

    assign req_idx    = bus.m_addr[IDX_MSB -: IDX_W];
    assign sel_ready  = bus.s_ready[idx];
    assign sel_rvalid = bus.s_rvalid[idx];
    assign slice      = bus.s_rdata[{idx, 5'd0} +: 32];
    assign active     = state == ISSUE || state == WAIT;

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clear(!active),
        .enable(active),
        .expired(expired)
    );

    // a completion in the expiry cycle takes priority over the timeout error
    always_comb begin
        state_nxt = state;
        err_nxt = 1'b0;
        case (state)
            IDLE: if (bus.m_valid) begin
                state_nxt = PRESENT_MASK[req_idx] ? ISSUE : DONE;
                err_nxt = !PRESENT_MASK[req_idx];
            end
            ISSUE: begin
                state_nxt = (sel_ready && sel_rvalid) || expired ? DONE : sel_ready ? WAIT : ISSUE;
                err_nxt = !(sel_ready && sel_rvalid) && expired;
            end
            WAIT: begin
                state_nxt = sel_rvalid || expired ? DONE : WAIT;
                err_nxt = !sel_rvalid && expired;
            end
            DONE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            s_valid_q <= '0;
            rvalid_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.m_valid) begin
                idx <= req_idx;
                we_q <= bus.m_we;
                addr_q <= bus.m_addr;
                wdata_q <= bus.m_wdata;
                wstrb_q <= bus.m_wstrb;
            end
            s_valid_q <= state_nxt == ISSUE ? onehot(state == IDLE ? req_idx : idx) : '0;
            rvalid_q <= state_nxt == DONE;
            err_q <= state_nxt == DONE && err_nxt;
            rdata_q <= state_nxt != DONE ? '0 : err_nxt ? ERR_DATA : slice;
        end
    end

    assign bus.m_ready  = state == IDLE;
    assign bus.m_rvalid = rvalid_q;
    assign bus.m_err    = err_q;
    assign bus.m_rdata  = rdata_q;
    assign bus.s_valid  = s_valid_q;
    assign bus.s_we     = we_q;
    assign bus.s_addr   = addr_q;
    assign bus.s_wdata  = wdata_q;
    assign bus.s_wstrb  = wstrb_q;
endmodule
